data_mem_responder: RTL and testbench

//   Responder end of the CPU data-memory interface: services load/store requests

---
 rtl/data_mem_responder.sv | 145 ++++++++++++++
 tb/tb_data_mem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Purpose: responder for the core data-memory port; word array behind a wait-state FSM.
// Latency: request seen in cycle 0 -> done/err pulse in cycle WAIT_CYCLES+1.
// Backpressure: stall is high while a request is accepted or waiting; the core holds PC.
module data_mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  // Counter reload; the zero-wait build never enters WAIT, so its value is unused there.
  localparam logic [7:0] CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic              capture;

  // Request captured at accept time; inputs are ignored after this.
  logic [ADDR_W-1:0] req_idx;
  logic              req_wr;
  logic              req_err;
  logic [15:0]       req_dat;

  // Live decode of the incoming request.
  logic [ADDR_W-1:0] in_idx;
  logic              in_err;

  // Access performed at the coming edge (from live inputs when there are no wait states).
  logic              acc_go;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_wr;
  logic              acc_err;
  logic [15:0]       acc_dat;

  logic [15:0]       mem [DEPTH];

  assign in_idx = addr[ADDR_W:1];
  // Misaligned, or any byte-address bit above the array set.
  assign in_err = addr[0] | (|(addr >> (ADDR_W + 1)));

  // Next-state, stall/done and access selection.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    acc_go    = 1'b0;
    acc_idx   = req_idx;
    acc_wr    = req_wr;
    acc_err   = req_err;
    acc_dat   = req_dat;
    stall     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        stall = enable;
        if (enable) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            acc_go    = 1'b1;
            acc_idx   = in_idx;
            acc_wr    = wr;
            acc_err   = in_err;
            acc_dat   = data_in;
            state_nxt = RESP;
          end else begin
            cnt_nxt   = CNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (cnt == 8'd0) begin
          acc_go    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RESP: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // err is only meaningful alongside done.
  assign err = done & req_err;

  // State and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; reset discards any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_idx <= '0;
      req_wr  <= 1'b0;
      req_err <= 1'b0;
      req_dat <= 16'd0;
    end else if (capture) begin
      req_idx <= in_idx;
      req_wr  <= wr;
      req_err <= in_err;
      req_dat <= data_in;
    end
  end

  // Load result register; stores and errored accesses leave it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= 16'd0;
    end else if (acc_go && !acc_wr && !acc_err) begin
      data_out <= mem[acc_idx];
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (acc_go && acc_wr && !acc_err) begin
      mem[acc_idx] <= acc_dat;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with 3 wait states, one with none.
// Expected responses are queued at issue time and popped by per-instance monitors on done.
// Stall/done timing is checked cycle by cycle by the stimulus tasks.
module tb_data_mem_responder;

  logic        clk;
  logic [1:0]  rst_v, en_v, wr_v, stall_v, done_v, err_v;
  logic [15:0] addr_v [2];
  logic [15:0] din_v  [2];
  logic [15:0] dout_v [2];

  int total = 0;
  int bad   = 0;

  logic [16:0] q0[$];
  logic [16:0] q1[$];

  data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .wr(wr_v[0]),
    .addr(addr_v[0]), .data_in(din_v[0]), .data_out(dout_v[0]),
    .stall(stall_v[0]), .done(done_v[0]), .err(err_v[0])
  );

  data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .wr(wr_v[1]),
    .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout_v[1]),
    .stall(stall_v[1]), .done(done_v[1]), .err(err_v[1])
  );

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard monitors: one pop per done pulse.
  always @(negedge clk) begin
    if (!rst_v[0] && done_v[0]) begin
      if (q0.size() == 0) check("w3_unexpected_done", 1, 0);
      else begin
        logic [16:0] e;
        e = q0.pop_front();
        check("w3_err", err_v[0], e[16]);
        check("w3_data_out", dout_v[0], e[15:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_v[1] && done_v[1]) begin
      if (q1.size() == 0) check("w0_unexpected_done", 1, 0);
      else begin
        logic [16:0] e;
        e = q1.pop_front();
        check("w0_err", err_v[1], e[16]);
        check("w0_data_out", dout_v[1], e[15:0]);
      end
    end
  end

  // Single access with enable held for exactly the accept cycle.
  task automatic do_acc(input int s, input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic e_err, input logic [15:0] e_dat);
    int wc;
    wc = (s == 0) ? 3 : 0;
    if (s == 0) q0.push_back({e_err, e_dat});
    else        q1.push_back({e_err, e_dat});
    @(posedge clk); #1;
    en_v[s] = 1'b1; wr_v[s] = w; addr_v[s] = a; din_v[s] = d;
    for (int c = 0; c <= wc; c++) begin
      @(negedge clk);
      check("stall_busy", stall_v[s], 1);
      check("done_early", done_v[s], 0);
      @(posedge clk); #1;
      en_v[s] = 1'b0;
    end
    @(negedge clk);
    check("stall_resp", stall_v[s], 0);
    check("done_resp", done_v[s], 1);
  endtask

  // Two loads with enable held high; optionally poke inputs during the first WAIT.
  task automatic two_loads(input logic [15:0] a1, input logic [15:0] a2, input logic poke,
                           input logic [15:0] d1, input logic [15:0] d2);
    logic [9:0] exp_stall, exp_done;
    exp_stall = 10'b01_1110_1111;  // bit c = cycle c
    exp_done  = 10'b10_0001_0000;
    q0.push_back({1'b0, d1});
    q0.push_back({1'b0, d2});
    @(posedge clk); #1;
    en_v[0] = 1'b1; wr_v[0] = 1'b0; addr_v[0] = a1; din_v[0] = 16'h0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("burst_stall", stall_v[0], exp_stall[c]);
      check("burst_done", done_v[0], exp_done[c]);
      @(posedge clk); #1;
      if (c + 1 == 1 && poke) begin
        addr_v[0] = a2; din_v[0] = 16'hFFFF; wr_v[0] = 1'b1;
      end
      if (c + 1 == 4) begin
        addr_v[0] = a2; wr_v[0] = 1'b0;
      end
      if (c + 1 == 6) en_v[0] = 1'b0;
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_v = 2'b11; en_v = 2'b00; wr_v = 2'b00;
    addr_v[0] = 16'h0; addr_v[1] = 16'h0;
    din_v[0]  = 16'h0; din_v[1]  = 16'h0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("rst_data_out", dout_v[s], 0);
      check("rst_stall", stall_v[s], 0);
      check("rst_done", done_v[s], 0);
      check("rst_err", err_v[s], 0);
    end
    @(posedge clk); #1;
    rst_v = 2'b00;

    // Store then load back.
    do_acc(0, 1'b1, 16'h0004, 16'hA5A5, 1'b0, 16'h0000);
    do_acc(0, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'hA5A5);

    // Errors: misaligned load, out-of-range store aliasing word 0.
    do_acc(0, 1'b1, 16'h0000, 16'h0F0F, 1'b0, 16'hA5A5);
    do_acc(0, 1'b0, 16'h0003, 16'h0000, 1'b1, 16'hA5A5);
    do_acc(0, 1'b1, 16'h0400, 16'h7777, 1'b1, 16'hA5A5);
    do_acc(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0F0F);

    // Reset in WAIT drops the pending store.
    do_acc(0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0F0F);
    @(posedge clk); #1;
    en_v[0] = 1'b1; wr_v[0] = 1'b1; addr_v[0] = 16'h0020; din_v[0] = 16'hBEEF;
    @(posedge clk); #1;
    en_v[0] = 1'b0;
    @(negedge clk);
    check("wait_stall", stall_v[0], 1);
    @(posedge clk); #1;
    rst_v[0] = 1'b1;
    @(negedge clk);
    check("midrst_data_out", dout_v[0], 0);
    check("midrst_stall", stall_v[0], 0);
    check("midrst_done", done_v[0], 0);
    check("midrst_err", err_v[0], 0);
    @(posedge clk); #1;
    rst_v[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_done", done_v[0], 0);
    end
    do_acc(0, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h1111);

    // Inputs changed during WAIT are ignored; enable held through RESP re-accepts.
    do_acc(0, 1'b1, 16'h0008, 16'h5A5A, 1'b0, 16'h1111);
    do_acc(0, 1'b1, 16'h000A, 16'h1234, 1'b0, 16'h1111);
    two_loads(16'h0008, 16'h000A, 1'b1, 16'h5A5A, 16'h1234);
    do_acc(0, 1'b0, 16'h000A, 16'h0000, 1'b0, 16'h1234);

    // Back-to-back loads.
    do_acc(0, 1'b1, 16'h0002, 16'h2222, 1'b0, 16'h1234);
    do_acc(0, 1'b1, 16'h0006, 16'h6666, 1'b0, 16'h1234);
    two_loads(16'h0002, 16'h0006, 1'b0, 16'h2222, 16'h6666);

    // Top word and a high-address error.
    do_acc(0, 1'b1, 16'h03FE, 16'hABCD, 1'b0, 16'h6666);
    do_acc(0, 1'b0, 16'h03FE, 16'h0000, 1'b0, 16'hABCD);
    do_acc(0, 1'b0, 16'h8000, 16'h0000, 1'b1, 16'hABCD);

    // Zero-wait instance.
    do_acc(1, 1'b1, 16'h0010, 16'h3C3C, 1'b0, 16'h0000);
    do_acc(1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h3C3C);
    do_acc(1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h3C3C);

    repeat (6) @(negedge clk);
    check("w3_sb_drained", q0.size(), 0);
    check("w0_sb_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
